// File: rtl/nla_pkg.sv
// Shared types and constants for the fixed-point nonlinear arithmetic blocks.
// Provides the Horner FSM state encoding and the signed saturation bounds.
package nla_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_FRAC    = 16;
    localparam int DEF_MAX_DEG = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } poly_state_t;

    // Signed range of a w-bit two's complement word (valid for w <= 63).
    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// One Horner step: y = sat(round((acc * x) >>> FRAC) + coef), with a clamp flag.
// Purely combinational; the caller registers y and accumulates the flag.
module fxp_mac
    import nla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic signed [WIDTH-1:0] acc,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] coef,
    output logic signed [WIDTH-1:0] y,
    output logic                    sat
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = WIDTH + 2;

    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC - 1);
    localparam logic signed [PW-1:0] P_HI = PW'(1) <<< WIDTH;
    localparam logic signed [PW-1:0] P_LO = -P_HI;
    localparam logic signed [SW-1:0] T_HI = SW'(1) <<< WIDTH;
    localparam logic signed [SW-1:0] T_LO = -T_HI;
    localparam logic signed [SW-1:0] Y_HI = SW'(sat_hi(WIDTH));
    localparam logic signed [SW-1:0] Y_LO = SW'(sat_lo(WIDTH));

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [SW-1:0] term;
    logic signed [SW-1:0] sum;

    // The scaled product is pinned to +/-2^WIDTH before the narrow add: any
    // value beyond that saturates for every legal coefficient, so the WIDTH+2
    // bit sum never wraps.
    always_comb begin
        prod    = PW'(acc) * PW'(x);
        shifted = (prod + RND) >>> FRAC;
        if (shifted > P_HI) begin
            term = T_HI;
        end else if (shifted < P_LO) begin
            term = T_LO;
        end else begin
            term = SW'(shifted);
        end
        sum = term + SW'(coef);
        sat = 1'b0;
        if (sum > Y_HI) begin
            y   = WIDTH'(Y_HI);
            sat = 1'b1;
        end else if (sum < Y_LO) begin
            y   = WIDTH'(Y_LO);
            sat = 1'b1;
        end else begin
            y   = WIDTH'(sum);
        end
    end

endmodule

// File: rtl/poly_horner_fxp.sv
// Sequential Horner evaluator of a signed fixed-point polynomial, one MAC per
// falling edge, with a writable coefficient bank and valid/ready job handshake.
module poly_horner_fxp
    import nla_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int FRAC    = DEF_FRAC,
    parameter int MAX_DEG = DEF_MAX_DEG,
    parameter int AW      = $clog2(MAX_DEG + 1)
) (
    input  logic                    clk_n,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [WIDTH-1:0] coef_wdata,
    input  logic [AW-1:0]           degree,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_y,
    output logic                    out_sat,
    output logic                    busy,
    output poly_state_t             fsm_state
);

    // Handshakes: a transfer happens on a falling edge where valid and ready
    // are both high; valid holds its payload stable until that edge.

    localparam logic [AW-1:0] DEG_MAX  = AW'(MAX_DEG);
    localparam bit            FULL_MAP = ((MAX_DEG + 1) == (1 << AW));
    localparam logic [AW-1:0] ONE      = AW'(1);

    poly_state_t             state;
    logic signed [WIDTH-1:0] coef_mem [MAX_DEG+1];
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] x_q;
    logic [AW-1:0]           k;
    logic                    sat_run;

    logic [AW-1:0]           d_sel;
    logic [AW-1:0]           k_m1;
    logic                    addr_ok;
    logic signed [WIDTH-1:0] mac_y;
    logic                    mac_sat;

    always_comb begin
        addr_ok = FULL_MAP || (int'(coef_addr) <= MAX_DEG);
        d_sel   = (FULL_MAP || (int'(degree) <= MAX_DEG)) ? degree : DEG_MAX;
        k_m1    = k - ONE;
    end

    fxp_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mac (
        .acc  (acc),
        .x    (x_q),
        .coef (coef_mem[k_m1]),
        .y    (mac_y),
        .sat  (mac_sat)
    );

    always_ff @(negedge clk_n) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            x_q       <= '0;
            k         <= '0;
            sat_run   <= 1'b0;
            out_y     <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            for (int i = 0; i <= MAX_DEG; i++) begin
                coef_mem[i] <= '0;
            end
        end else begin
            // A job accepted on this same edge reads the old word via NBA ordering.
            if ((state == ST_IDLE) && coef_we && addr_ok) begin
                coef_mem[coef_addr] <= coef_wdata;
            end
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_x;
                        acc     <= coef_mem[d_sel];
                        k       <= d_sel;
                        sat_run <= 1'b0;
                        if (d_sel == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out_y     <= coef_mem[d_sel];
                            out_sat   <= 1'b0;
                        end else begin
                            state <= ST_STEP;
                        end
                    end
                end
                ST_STEP: begin
                    acc     <= mac_y;
                    sat_run <= sat_run | mac_sat;
                    k       <= k_m1;
                    if (k == ONE) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_y     <= mac_y;
                        out_sat   <= sat_run | mac_sat;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_poly_horner_fxp.sv
// Directed bench for poly_horner_fxp: hand-derived Q16.16 results are queued
// per job and popped when out_valid appears.
module tb_poly_horner_fxp;
    import nla_pkg::*;

    localparam int W = 32;

    logic         clk_n = 1'b1;
    logic         rst = 1'b1;
    logic         coef_we = 1'b0;
    logic [2:0]   coef_addr = '0;
    logic [W-1:0] coef_wdata = '0;
    logic [2:0]   degree = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_y;
    logic         out_sat;
    logic         busy;
    poly_state_t  fsm_state;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int accept_edge = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_sat_q[$];
    int           exp_lat_q[$];

    poly_horner_fxp dut (
        .clk_n      (clk_n),
        .rst        (rst),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .degree     (degree),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_sat    (out_sat),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    always #5 clk_n = ~clk_n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_n);
        #1;
        edge_cnt++;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic [W-1:0] val);
        coef_we    = 1'b1;
        coef_addr  = addr;
        coef_wdata = val;
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic expect_result(input logic [W-1:0] ey, input logic es, input int lat);
        exp_q.push_back(ey);
        exp_sat_q.push_back(es);
        exp_lat_q.push_back(lat);
    endtask

    task automatic start_job(input logic [2:0] deg, input logic [W-1:0] x);
        int guard;
        degree   = deg;
        in_x     = x;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_wait", W'(in_ready), W'(1));
        tick();
        accept_edge = edge_cnt;
        in_valid = 1'b0;
        check("busy_after_accept", W'(busy), W'(1));
    endtask

    task automatic wait_result();
        int guard;
        logic [W-1:0] ey;
        logic         es;
        int           el;
        guard = 0;
        while (!out_valid && guard < 40) begin
            tick();
            guard++;
        end
        check("out_valid_wait", W'(out_valid), W'(1));
        ey = exp_q.pop_front();
        es = exp_sat_q.pop_front();
        el = exp_lat_q.pop_front();
        check("latency", W'(edge_cnt - accept_edge + 1), W'(el));
        check("out_y", out_y, ey);
        check("out_sat", W'(out_sat), W'(es));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", W'(out_valid), W'(0));
        check("in_ready_back", W'(in_ready), W'(1));
    endtask

    task automatic run_job(input logic [2:0] deg, input logic [W-1:0] x,
                           input logic [W-1:0] ey, input logic es, input int lat);
        expect_result(ey, es, lat);
        start_job(deg, x);
        wait_result();
        release_result();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_out_y", out_y, 32'h0);
        check("rst_out_sat", W'(out_sat), W'(0));
        check("rst_state", W'(fsm_state), W'(ST_IDLE));

        // 3x^2 + 2x + 1 at x = 2.0 -> 17.0
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd1, 32'h0002_0000);
        write_coef(3'd2, 32'h0003_0000);
        run_job(3'd2, 32'h0002_0000, 32'h0011_0000, 1'b0, 3);
        check("hold_out_y_idle", out_y, 32'h0011_0000);

        // Degree 0 returns c0 after a single edge
        write_coef(3'd0, 32'hFFFF_8000);
        run_job(3'd0, $urandom(), 32'hFFFF_8000, 1'b0, 1);

        // Degree 7, c_k = k+1, x = 1.0 -> 36.0
        for (int i = 0; i < 8; i++) begin
            write_coef(3'(i), W'(i + 1) << 16);
        end
        run_job(3'd7, 32'h0001_0000, 32'h0024_0000, 1'b0, 8);

        // Round half up on the scaled product, x = 0.5
        write_coef(3'd0, 32'h0);
        write_coef(3'd1, 32'h0000_0001);
        run_job(3'd1, 32'h0000_8000, 32'h0000_0001, 1'b0, 2);
        write_coef(3'd1, 32'hFFFF_FFFF);
        run_job(3'd1, 32'h0000_8000, 32'h0000_0000, 1'b0, 2);
        write_coef(3'd1, 32'h0000_0003);
        run_job(3'd1, 32'h0000_8000, 32'h0000_0002, 1'b0, 2);
        write_coef(3'd1, 32'hFFFF_FFFD);
        run_job(3'd1, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0, 2);

        // Saturation at both rails
        write_coef(3'd1, 32'h7FFF_0000);
        run_job(3'd1, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1, 2);
        write_coef(3'd1, 32'h8000_0000);
        run_job(3'd1, 32'h0002_0000, 32'h8000_0000, 1'b1, 2);

        // Clamp in the first step only; flag must stick to the final result
        write_coef(3'd2, 32'h8000_0000);
        write_coef(3'd1, 32'h0);
        run_job(3'd2, 32'hFFFF_0000, 32'h8000_0001, 1'b1, 3);

        // Back-pressure in DONE with in_valid and a dropped coefficient write
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd1, 32'h0002_0000);
        write_coef(3'd2, 32'h0003_0000);
        expect_result(32'h0011_0000, 1'b0, 3);
        start_job(3'd2, 32'h0002_0000);
        wait_result();
        in_valid   = 1'b1;
        degree     = 3'd0;
        in_x       = 32'h1234_5678;
        coef_we    = 1'b1;
        coef_addr  = 3'd0;
        coef_wdata = 32'h0000_7777;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", W'(out_valid), W'(1));
            check("stall_out_y", out_y, 32'h0011_0000);
            check("stall_in_ready", W'(in_ready), W'(0));
        end
        check("stall_state", W'(fsm_state), W'(ST_DONE));
        coef_we   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stall_release_ready", W'(in_ready), W'(1));
        check("stall_release_valid", W'(out_valid), W'(0));
        check("stall_keep_out_y", out_y, 32'h0011_0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_extra_job", W'(out_valid), W'(0));
        end
        run_job(3'd2, 32'h0002_0000, 32'h0011_0000, 1'b0, 3);

        // Coefficient write during STEP is dropped
        expect_result(32'h0011_0000, 1'b0, 3);
        start_job(3'd2, 32'h0002_0000);
        coef_we    = 1'b1;
        coef_addr  = 3'd1;
        coef_wdata = 32'h0050_0000;
        tick();
        coef_we    = 1'b0;
        wait_result();
        release_result();
        run_job(3'd2, 32'h0002_0000, 32'h0011_0000, 1'b0, 3);

        // Reset mid-STEP discards the job and clears the bank
        start_job(3'd3, 32'h0002_0000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_out_y", out_y, 32'h0);
        run_job(3'd3, 32'h0002_0000, 32'h0000_0000, 1'b0, 4);

        check("queue_drained", W'(exp_q.size()), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/poly_horner_fxp.md
POLY_HORNER_FXP -- requirements
Module: poly_horner_fxp

Interface
REQ-001 Parameter WIDTH, default 32, signed fixed-point word width of x, coefficients and result.
REQ-002 Parameter FRAC, default 16, fractional bits (Q(WIDTH-FRAC).FRAC); 1 <= FRAC < WIDTH.
REQ-003 Parameter MAX_DEG, default 7, highest supported polynomial degree; AW = clog2(MAX_DEG+1).
REQ-004 clk_n  in  1  clock; single clock domain; all state updates on falling edge of clk_n.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 coef_we  in  1  coefficient write strobe.
REQ-007 coef_addr  in  AW  coefficient index k (term c_k * x^k).
REQ-008 coef_wdata  in  WIDTH  coefficient value, signed Q format.
REQ-009 degree  in  AW  polynomial degree for next job, sampled at input handshake.
REQ-010 in_valid  in  1  x operand valid.
REQ-011 in_ready  out  1  block can accept x.
REQ-012 in_x  in  WIDTH  evaluation point, signed Q format.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 out_y  out  WIDTH  result, signed Q format.
REQ-016 out_sat  out  1  saturation occurred in any step of current result.
REQ-017 busy  out  1  high whenever FSM not IDLE.

Function
REQ-018 FSM states IDLE, STEP, DONE; in_ready = (state == IDLE).
REQ-019 IDLE, in_valid: capture x, d = min(degree, MAX_DEG), acc <= c[d], k <= d, out_sat cleared; d == 0 -> DONE, else -> STEP.
REQ-020 STEP, each edge: acc <= sat(rnd((acc * x) >>> FRAC) + c[k-1]); k <= k-1; if k == 1 -> DONE.
REQ-021 Product: full 2*WIDTH signed; rounding adds 2^(FRAC-1) before arithmetic shift right by FRAC (round half up).
REQ-022 Sum computed at WIDTH+2 bits, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any clamp in any step sets out_sat sticky for the job.
REQ-023 DONE: out_valid = 1, out_y = acc; both held stable until out_ready; on out_valid & out_ready -> IDLE.
REQ-024 Latency: out_valid asserts d+1 falling edges after the accepting edge; throughput one job per d+2 cycles minimum.
REQ-025 out_y and out_sat keep last result after leaving DONE until next result is produced.
REQ-026 Coefficient bank: MAX_DEG+1 words; coef_we honoured only in IDLE; writes in STEP or DONE dropped silently.
REQ-027 coef_addr > MAX_DEG: write dropped.
REQ-028 Same edge coef_we and input handshake in IDLE: job uses pre-write coefficient value; write still commits.
REQ-029 in_valid while busy: no capture; upstream holds (standard valid/ready, no loss).

Reset
REQ-030 rst high at an edge: state IDLE, acc 0, k 0, out_y 0, out_valid 0, out_sat 0, all coefficients 0.
REQ-031 rst overrides all other inputs, including mid-STEP and DONE; in-flight job discarded, no out_valid.
REQ-032 First edge after rst deasserts: in_ready = 1, job acceptable.

Structure
REQ-033 Shared package nla_pkg: FSM state enum, default WIDTH/FRAC/MAX_DEG constants, signed saturation limits.
REQ-034 One sub-module fxp_mac (combinational multiply, round, add, saturate, sat flag) parametrised WIDTH/FRAC; FSM and coefficient bank in poly_horner_fxp.

Verification (WIDTH 32, FRAC 16, MAX_DEG 7)
REQ-035 c0=0x00010000, c1=0x00020000, c2=0x00030000, degree 2, x=0x00020000 -> out_y=0x00110000 (17.0), out_sat 0, out_valid 3 edges after accept.
REQ-036 degree 0, c0=0xFFFF8000, any x -> out_y=0xFFFF8000 after 1 edge; degree 7 with degree input 7 -> 8 edges.
REQ-037 c1=0x7FFF0000, c0=0, degree 1, x=0x00020000 -> out_y=0x7FFFFFFF, out_sat 1; negative mirror c1=0x80000000 -> 0x80000000, out_sat 1.
REQ-038 out_ready low 5 cycles in DONE -> out_y, out_valid stable, in_ready 0, in_valid ignored; out_ready high -> IDLE next edge.
REQ-039 coef_we to c1 during STEP -> result unaffected, c1 unchanged on next job.
REQ-040 rst pulsed mid-STEP -> next edge out_valid 0, in_ready 1, all coefficients read back as 0 (degree 3 job yields out_y 0).
